// File: rtl/mealy_seq_detect_if.sv
// Sample/config/result bundle for mealy_seq_detect.
// Latency: none of its own; pure wiring between driver and detector.
// Backpressure: none; samples are qualified by in_valid only, and there is no ready.
//
// Port summary (slave = detector side):
//   in_valid, i, nonovl        : sample stream and overlap mode
//   cfg_we, cfg_sel, cfg_pat,  : per-channel pattern/mask write port
//   cfg_mask
//   cnt_clr                    : synchronous clear of the match counters
//   match, any_match, cnt      : Mealy match flags and per-channel counters
interface mealy_seq_detect_if #(
  parameter int LEN  = 3,
  parameter int NPAT = 2,
  parameter int CNTW = 8
);
  localparam int SELW = (NPAT > 1) ? $clog2(NPAT) : 1;

  logic                 in_valid;
  logic                 i;
  logic                 nonovl;
  logic                 cfg_we;
  logic [SELW-1:0]      cfg_sel;
  logic [LEN-1:0]       cfg_pat;
  logic [LEN-1:0]       cfg_mask;
  logic                 cnt_clr;
  logic [NPAT-1:0]      match;
  logic                 any_match;
  logic [NPAT*CNTW-1:0] cnt;

  modport master (
    output in_valid, i, nonovl, cfg_we, cfg_sel, cfg_pat, cfg_mask, cnt_clr,
    input  match, any_match, cnt
  );

  modport slave (
    input  in_valid, i, nonovl, cfg_we, cfg_sel, cfg_pat, cfg_mask, cnt_clr,
    output match, any_match, cnt
  );
endinterface

// File: rtl/mealy_seq_detect.sv
// Multi-channel serial pattern detector with Mealy (combinational) match outputs.
// Latency: match/any_match are valid in the same cycle as the sample (0 clocks).
// Backpressure: none; in_valid=0 freezes all state and forces match to 0.
//
// Ports:
//   clock    : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mealy_seq_detect_if.slave (sample stream, config port, results)
// Optional feature: define MEALY_MATCH_CNT_EN to build saturating per-channel
// match counters; without it the cnt field is tied to zero and cnt_clr is unused.
module mealy_seq_detect #(
  parameter int LEN  = 3,
  parameter int NPAT = 2,
  parameter int CNTW = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  mealy_seq_detect_if.slave       bus
);

  localparam int FILLW = $clog2(LEN);
  localparam int SELW  = (NPAT > 1) ? $clog2(NPAT) : 1;

  // History of previous samples: bit 0 is the most recent valid sample.
  logic [LEN-2:0]  hist_q, hist_d;
  // Number of valid samples seen since reset / last non-overlapping match.
  logic [FILLW-1:0] fill_q, fill_d;

  logic [LEN-1:0]  pat_q  [NPAT];
  logic [LEN-1:0]  pat_d  [NPAT];
  logic [LEN-1:0]  mask_q [NPAT];
  logic [LEN-1:0]  mask_d [NPAT];

  logic            filled;
  logic [LEN-1:0]  window;
  logic [NPAT-1:0] match_c;
  logic            any_c;

  // ------------------------------------------------------------------
  // Mealy match: the current sample joins the stored history as bit 0.
  // Because fill is cleared by reset, match drops to 0 asynchronously
  // as soon as reset_n is asserted.
  // ------------------------------------------------------------------
  always_comb begin
    filled  = (fill_q == FILLW'(LEN - 1));
    window  = {hist_q, bus.i};
    match_c = '0;
    for (int p = 0; p < NPAT; p++) begin
      match_c[p] = bus.in_valid & filled &
                   (((window ^ pat_q[p]) & mask_q[p]) == '0);
    end
    any_c = |match_c;
  end

  assign bus.match     = match_c;
  assign bus.any_match = any_c;

  // ------------------------------------------------------------------
  // History / fill next state.
  // ------------------------------------------------------------------
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.in_valid) begin
      // Dropping the oldest bit of the window gives the shifted history,
      // which also covers LEN=2 where the history is a single bit.
      hist_d = window[LEN-2:0];
      if (bus.nonovl && any_c) begin
        // Non-overlapping mode: the matched samples cannot be reused.
        fill_d = '0;
      end else if (!filled) begin
        fill_d = fill_q + FILLW'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Pattern/mask write port. Channel selects outside 0..NPAT-1 never hit
  // a loop index, so such writes are dropped. Writes take effect at the
  // edge, so a match in the writing cycle still uses the old pattern.
  // ------------------------------------------------------------------
  always_comb begin
    pat_d  = pat_q;
    mask_d = mask_q;
    if (bus.cfg_we) begin
      for (int p = 0; p < NPAT; p++) begin
        if (bus.cfg_sel == SELW'(p)) begin
          pat_d[p]  = bus.cfg_pat;
          mask_d[p] = bus.cfg_mask;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      for (int p = 0; p < NPAT; p++) begin
        // Even channels look for a run of ones, odd channels for a single
        // one after LEN-1 zeros.
        pat_q[p]  <= (p % 2 == 0) ? {LEN{1'b1}} : LEN'(1);
        mask_q[p] <= {LEN{1'b1}};
      end
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mask_q <= mask_d;
    end
  end

`ifdef MEALY_MATCH_CNT_EN
  // ------------------------------------------------------------------
  // Saturating per-channel match counters; clear has priority over a
  // simultaneous match.
  // ------------------------------------------------------------------
  logic [CNTW-1:0]      cnt_q [NPAT];
  logic [CNTW-1:0]      cnt_d [NPAT];
  logic [NPAT*CNTW-1:0] cnt_flat;

  always_comb begin
    cnt_d    = cnt_q;
    cnt_flat = '0;
    for (int p = 0; p < NPAT; p++) begin
      if (bus.cnt_clr) begin
        cnt_d[p] = '0;
      end else if (match_c[p] && (cnt_q[p] != {CNTW{1'b1}})) begin
        cnt_d[p] = cnt_q[p] + CNTW'(1);
      end
      cnt_flat[p*CNTW +: CNTW] = cnt_q[p];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPAT; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.cnt = cnt_flat;
`else
  // Counters not built: the field reads as zero and the clear is unused.
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.cnt        = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detect.sv
module tb_mealy_seq_detect;
  localparam int LEN  = 3;
  localparam int NPAT = 2;
  localparam int CNTW = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mealy_seq_detect_if #(.LEN(LEN), .NPAT(NPAT), .CNTW(CNTW)) bus_if ();

  mealy_seq_detect #(.LEN(LEN), .NPAT(NPAT), .CNTW(CNTW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  typedef struct {
    logic       vld;
    logic       din;
    logic       nov;
    logic [1:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [CNTW-1:0] mc [NPAT];

  vec_t t37  [10];
  vec_t t38a [6];
  vec_t t38b [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
    logic [31:0] r;
    r = '0;
    for (int p = 0; p < NPAT; p++) r[p*CNTW +: CNTW] = mc[p];
    return r;
  endfunction

  // Drive one cycle at posedge+1, check the Mealy outputs mid-cycle,
  // then check the counters after the edge.
  task automatic step(input logic v, input logic b, input logic nov,
                      input logic [1:0] em, input string nm);
    bus_if.in_valid = v;
    bus_if.i        = b;
    bus_if.nonovl   = nov;
    #3;
    check({nm, " match"}, 32'(bus_if.match), 32'(em));
    check({nm, " any"}, 32'(bus_if.any_match), 32'(|em));
    @(posedge clock);
    #1;
`ifdef MEALY_MATCH_CNT_EN
    for (int p = 0; p < NPAT; p++) begin
      if (bus_if.cnt_clr) mc[p] = '0;
      else if (v && em[p] && (mc[p] != {CNTW{1'b1}})) mc[p] = mc[p] + 1'b1;
    end
`endif
    check({nm, " cnt"}, 32'(bus_if.cnt), exp_cnt());
    bus_if.cfg_we  = 1'b0;
    bus_if.cnt_clr = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    #2;
    for (int p = 0; p < NPAT; p++) mc[p] = '0;
    check({nm, " rst match"}, 32'(bus_if.match), 32'd0);
    check({nm, " rst cnt"}, 32'(bus_if.cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.i        = 1'b0;
    bus_if.nonovl   = 1'b0;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_sel  = '0;
    bus_if.cfg_pat  = '0;
    bus_if.cfg_mask = '0;
    bus_if.cnt_clr  = 1'b0;
    for (int p = 0; p < NPAT; p++) mc[p] = '0;

    // Sequence 1,1,1,0,0,1,1,0,0,1: ch0 (111) at 2, ch1 (001) at 5 and 9.
    t37 = '{'{1'b1, 1'b1, 1'b0, 2'b00}, '{1'b1, 1'b1, 1'b0, 2'b00},
            '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b0, 1'b0, 2'b00},
            '{1'b1, 1'b0, 1'b0, 2'b00}, '{1'b1, 1'b1, 1'b0, 2'b10},
            '{1'b1, 1'b1, 1'b0, 2'b00}, '{1'b1, 1'b0, 1'b0, 2'b00},
            '{1'b1, 1'b0, 1'b0, 2'b00}, '{1'b1, 1'b1, 1'b0, 2'b10}};
    // Six ones, overlapping: ch0 at 2..5.
    t38a = '{'{1'b1, 1'b1, 1'b0, 2'b00}, '{1'b1, 1'b1, 1'b0, 2'b00},
             '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 2'b01},
             '{1'b1, 1'b1, 1'b0, 2'b01}, '{1'b1, 1'b1, 1'b0, 2'b01}};
    // Six ones, non-overlapping: ch0 at 2 and 5 only.
    t38b = '{'{1'b1, 1'b1, 1'b1, 2'b00}, '{1'b1, 1'b1, 1'b1, 2'b00},
             '{1'b1, 1'b1, 1'b1, 2'b01}, '{1'b1, 1'b1, 1'b1, 2'b00},
             '{1'b1, 1'b1, 1'b1, 2'b00}, '{1'b1, 1'b1, 1'b1, 2'b01}};

    // Reset state, inputs idle.
    #2;
    check("init match", 32'(bus_if.match), 32'd0);
    check("init any", 32'(bus_if.any_match), 32'd0);
    check("init cnt", 32'(bus_if.cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++)
      step(t37[k].vld, t37[k].din, t37[k].nov, t37[k].exp, $sformatf("seq37[%0d]", k));

    do_reset("r38a");
    for (int k = 0; k < 6; k++)
      step(t38a[k].vld, t38a[k].din, t38a[k].nov, t38a[k].exp, $sformatf("ovl[%0d]", k));

    do_reset("r38b");
    for (int k = 0; k < 6; k++)
      step(t38b[k].vld, t38b[k].din, t38b[k].nov, t38b[k].exp, $sformatf("nonovl[%0d]", k));

    // Same sequence with idle gaps where i toggles: gaps never match.
    do_reset("r39");
    for (int k = 0; k < 10; k++) begin
      step(t37[k].vld, t37[k].din, t37[k].nov, t37[k].exp, $sformatf("gap37[%0d]", k));
      step(1'b0, ~t37[k].din, 1'b0, 2'b00, $sformatf("gap[%0d]", k));
    end

    // Config write in the same cycle as an old-pattern match.
    do_reset("r40");
    step(1'b1, 1'b1, 1'b0, 2'b00, "cfg a");
    step(1'b1, 1'b1, 1'b0, 2'b00, "cfg b");
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_sel  = 1'b0;
    bus_if.cfg_pat  = 3'b010;
    bus_if.cfg_mask = 3'b111;
    step(1'b1, 1'b1, 1'b0, 2'b01, "cfg old pat");
    step(1'b1, 1'b0, 1'b0, 2'b00, "new pat 0");
    step(1'b1, 1'b1, 1'b0, 2'b00, "new pat 1");
    step(1'b1, 1'b0, 1'b0, 2'b01, "new pat 010");
    // ch1 mask=0 written during an idle cycle: history must survive it,
    // and ch1 then matches on every valid sample.
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_sel  = 1'b1;
    bus_if.cfg_pat  = 3'b001;
    bus_if.cfg_mask = 3'b000;
    step(1'b0, 1'b1, 1'b0, 2'b00, "cfg idle");
    step(1'b1, 1'b0, 1'b0, 2'b10, "mask0 a");
    step(1'b1, 1'b1, 1'b0, 2'b10, "mask0 b");

    // Counter saturation and clear priority.
    do_reset("r41");
    step(1'b1, 1'b1, 1'b0, 2'b00, "cnt s0");
    step(1'b1, 1'b1, 1'b0, 2'b00, "cnt s1");
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 2'b01, $sformatf("cnt m%0d", k));
`ifdef MEALY_MATCH_CNT_EN
    check("cnt sat ch0", 32'(bus_if.cnt[CNTW-1:0]), 32'd3);
`else
    check("cnt off ch0", 32'(bus_if.cnt[CNTW-1:0]), 32'd0);
`endif
    bus_if.cnt_clr = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'b01, "cnt clr+match");
    check("cnt after clr", 32'(bus_if.cnt), 32'd0);
    step(1'b1, 1'b1, 1'b0, 2'b01, "cnt after clr m");

    // Reset in the middle of a sequence that was about to match.
    do_reset("r42");
    step(1'b1, 1'b1, 1'b0, 2'b00, "pre a");
    step(1'b1, 1'b1, 1'b0, 2'b00, "pre b");
    bus_if.in_valid = 1'b1;
    bus_if.i        = 1'b1;
    #2;
    check("pre-rst match", 32'(bus_if.match), 32'd1);
    reset_n = 1'b0;
    #1;
    for (int p = 0; p < NPAT; p++) mc[p] = '0;
    check("async rst match", 32'(bus_if.match), 32'd0);
    check("async rst any", 32'(bus_if.any_match), 32'd0);
    check("async rst cnt", 32'(bus_if.cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 2'b00, "post a");
    step(1'b1, 1'b1, 1'b0, 2'b00, "post b");
    step(1'b1, 1'b1, 1'b0, 2'b01, "post c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mealy_seq_detect.md
MEALY_SEQ_DETECT -- requirements
Module: mealy_seq_detect

Interface
REQ-001 Parameter LEN, default 3: pattern length in samples, including the current sample; range 2..16.
REQ-002 Parameter NPAT, default 2: number of independent pattern channels; range 1..8.
REQ-003 Parameter CNTW, default 8: match-counter width per channel.
REQ-004 clock  in  1: sole clock, rising edge.
REQ-005 reset_n  in  1: asynchronous, active-low reset.
REQ-006 in_valid  in  1: qualifies i; the history shifts only when in_valid=1.
REQ-007 i  in  1: serial input sample.
REQ-008 nonovl  in  1: 1 selects non-overlapping detection, 0 selects overlapping detection.
REQ-009 cfg_we  in  1: pattern/mask write strobe.
REQ-010 cfg_sel  in  $clog2(NPAT) (min 1): channel to write.
REQ-011 cfg_pat  in  LEN: pattern; bit 0 = current sample, bit k = sample k valid cycles earlier.
REQ-012 cfg_mask  in  LEN: per-bit compare enable, 1 = compare.
REQ-013 cnt_clr  in  1: synchronous clear of all match counters.
REQ-014 match  out  NPAT: per-channel Mealy match.
REQ-015 any_match  out  1: OR of match.
REQ-016 cnt  out  NPAT*CNTW: match counters; channel p occupies bits [p*CNTW +: CNTW].

Function
REQ-017 The history register hist[LEN-2:0] SHALL shift on clock when in_valid=1: hist[0] <= i, hist[k] <= hist[k-1].
REQ-018 The fill counter SHALL increment on each valid sample and saturate at LEN-1; filled = (fill == LEN-1).
REQ-019 match[p] SHALL be combinational (Mealy): in_valid & filled & (((({hist,i}) ^ pat[p]) & mask[p]) == 0).
REQ-020 match changes within the same cycle as i, with zero clock latency; no output register.
REQ-021 The registered state SHALL update on the clock edge that ends the cycle in which match is asserted.
REQ-022 A channel with mask = 0 SHALL match on every valid sample once filled.
REQ-023 With nonovl=1 and any_match=1 on a valid sample, fill SHALL reset to 0 at that edge; the history still shifts.
REQ-024 With nonovl=0, fill SHALL be unaffected by matches.
REQ-025 On cfg_we, pat/mask[cfg_sel] SHALL update at the clock edge.
REQ-026 A same-cycle match uses the old pattern; the new pattern applies from the next cycle.
REQ-027 A cfg write SHALL NOT alter hist or fill.
REQ-028 A cfg_sel value >= NPAT SHALL make the write ignored.
REQ-029 Samples with in_valid=0 SHALL leave all state unchanged and force match=0.

Reset
REQ-030 On reset_n=0: hist=0, fill=0, all counters=0, match=0, any_match=0, cnt=0, immediately and asynchronously.
REQ-031 Reset values of pattern/mask: even channels pat=all-ones; odd channels pat=1 at bit 0, zeros elsewhere; all masks all-ones.
REQ-032 Reset asserted mid-sequence SHALL discard partial history; after release, LEN-1 valid samples are needed before any match.

Configuration
REQ-033 Macro MEALY_MATCH_CNT_EN defined: each valid sample with match[p]=1 increments counter p at the edge.
REQ-034 With MEALY_MATCH_CNT_EN, counters SHALL saturate at 2^CNTW-1.
REQ-035 With MEALY_MATCH_CNT_EN and simultaneous cnt_clr and match, clear SHALL win (result 0).
REQ-036 Macro MEALY_MATCH_CNT_EN undefined: no counter registers; the cnt port remains present and is tied to 0; cnt_clr is ignored.

Verification
REQ-037 Defaults, nonovl=0, in_valid=1, i = 1,1,1,0,0,1,1,0,0,1 (sample 0 first) -> match=2'b01 at sample 2 and 2'b10 at samples 5 and 9; 0 elsewhere.
REQ-038 Defaults, i = 1 for 6 samples: nonovl=0 -> match[0] at samples 2,3,4,5; nonovl=1 -> match[0] at samples 2 and 5 only.
REQ-039 Insert in_valid=0 cycles with i toggling between the samples of REQ-037 -> identical match sequence; match=0 during the gaps.
REQ-040 Write ch0 pat=3'b010, mask=3'b111, then feed i=0,1,0 -> match[0] at the third sample. Issue cfg_we on the same cycle as an old-pattern match -> the match is still reported.
REQ-041 MEALY_MATCH_CNT_EN, CNTW=2, 5 matches on ch0 -> cnt ch0 = 3. Then cnt_clr together with a match -> cnt = 0. Without the macro, cnt = 0 throughout.
REQ-042 Assert reset_n=0 after 2 samples of 1, release, feed 1,1 -> no match. The third 1 -> match[0]. Outputs are 0 asynchronously while reset is asserted.
